// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the word for decode, squashes on redirect and parks on misaligned targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr_q, instr_next;
  logic [31:0] instr_pc_q, instr_pc_next;
  logic [31:0] tgt, tgt_next;
  logic        kill, kill_next;
  logic        fault_pend, fault_pend_next;
  logic [31:0] eff_tgt;
  logic        eff_mis;

  // A redirect arriving with the ack is newer than any latched target.
  assign eff_tgt = redirect ? redirect_target : tgt;
  assign eff_mis = redirect ? (redirect_target[1:0] != 2'b00) : fault_pend;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    state_next      = state;
    pc_next         = pc;
    instr_next      = instr_q;
    instr_pc_next   = instr_pc_q;
    tgt_next        = tgt;
    kill_next       = kill;
    fault_pend_next = fault_pend;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (imem_ack) begin
          if (!kill && !redirect) begin
            instr_next    = imem_rdata;
            instr_pc_next = pc;
            state_next    = HOLD;
          end else if (eff_mis) begin
            state_next = FAULT;
          end else begin
            pc_next         = eff_tgt;
            kill_next       = 1'b0;
            fault_pend_next = 1'b0;
          end
        end else if (redirect) begin
          // Address must stay stable until ack, so only remember the target.
          kill_next       = 1'b1;
          tgt_next        = redirect_target;
          fault_pend_next = (redirect_target[1:0] != 2'b00);
        end
      end
      HOLD: begin
        if (redirect) begin
          if (redirect_target[1:0] != 2'b00) begin
            state_next = FAULT;
          end else begin
            pc_next    = redirect_target;
            state_next = FETCH;
          end
        end else if (instr_ready) begin
          pc_next    = pc + 32'd4;
          state_next = FETCH;
        end
      end
      FAULT: state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
      tgt        <= RESET_PC;
      kill       <= 1'b0;
      fault_pend <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_next;
      pc         <= pc_next;
      instr_q    <= instr_next;
      instr_pc_q <= instr_pc_next;
      tgt        <= tgt_next;
      kill       <= kill_next;
      fault_pend <= fault_pend_next;
    end
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign fetch_fault = (state == FAULT);
  assign instr       = (state == HOLD) ? instr_q : NOP_INSTR;
  assign op          = instr[6:0];
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = instr_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, wait states, decode stall,
// redirects (in HOLD, during fetch, with ack), PC wrap, misaligned fault, async reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;

  logic auto_ack, man_ack;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0033};
  endfunction

  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = mem_word(imem_addr);

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_target(redirect_target),
    .instr_ready(instr_ready), .instr_valid(instr_valid),
    .instr(instr), .op(op), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .fetch_fault(fetch_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] addr);
    check({tag, " req"},   32'(imem_req), 32'd1);
    check({tag, " addr"},  imem_addr, addr);
    check({tag, " valid"}, 32'(instr_valid), 32'd0);
  endtask

  task automatic expect_hold(input string tag, input logic [31:0] pc);
    check({tag, " valid"},  32'(instr_valid), 32'd1);
    check({tag, " req"},    32'(imem_req), 32'd0);
    check({tag, " instr"},  instr, mem_word(pc));
    check({tag, " op"},     32'(op), 32'h33);
    check({tag, " ipc"},    instr_pc, pc);
    check({tag, " plus4"},  pc_plus4, pc + 32'd4);
  endtask

  initial begin
    rst_n = 1'b0; auto_ack = 1'b0; man_ack = 1'b0;
    redirect = 1'b0; redirect_target = '0; instr_ready = 1'b1;
    #2;
    check("rst req",   32'(imem_req), 32'd0);
    check("rst addr",  imem_addr, 32'h0);
    check("rst valid", 32'(instr_valid), 32'd0);
    check("rst instr", instr, 32'h13);
    check("rst op",    32'(op), 32'h13);
    check("rst ipc",   instr_pc, 32'h0);
    check("rst plus4", pc_plus4, 32'h4);
    check("rst fault", 32'(fetch_fault), 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    check("idle req", 32'(imem_req), 32'd0);
    auto_ack = 1'b1;
    step();

    // Zero-wait memory: valid every other cycle, addresses 0,4,8,12.
    for (int i = 0; i < 4; i++) begin
      expect_fetch($sformatf("seq%0d", i), 32'(i * 4));
      step();
      expect_hold($sformatf("seq%0d", i), 32'(i * 4));
      if (i == 3) auto_ack = 1'b0;
      step();
    end

    // Three wait cycles at address 16.
    for (int i = 0; i < 3; i++) begin
      expect_fetch($sformatf("wait%0d", i), 32'h10);
      step();
    end
    man_ack = 1'b1;
    expect_fetch("ackcyc", 32'h10);
    step();
    man_ack = 1'b0;
    expect_hold("delayed", 32'h10);

    // Decode stall for 4 cycles.
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_hold($sformatf("stall%0d", i), 32'h10);
    end
    instr_ready = 1'b1;
    step();
    expect_fetch("after stall", 32'h14);

    // Redirect in HOLD beats pc+4.
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    expect_hold("hold14", 32'h14);
    redirect = 1'b1; redirect_target = 32'h100;
    step();
    redirect = 1'b0;
    expect_fetch("redir hold", 32'h100);

    // Redirect two cycles before a delayed ack: acked data squashed.
    redirect = 1'b1; redirect_target = 32'h200;
    step();
    redirect = 1'b0;
    expect_fetch("kill stable0", 32'h100);
    step();
    expect_fetch("kill stable1", 32'h100);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    expect_fetch("kill new", 32'h200);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    expect_hold("hold200", 32'h200);

    // Redirect coinciding with ack.
    step();
    expect_fetch("seq204", 32'h204);
    man_ack = 1'b1; redirect = 1'b1; redirect_target = 32'h300;
    step();
    man_ack = 1'b0; redirect = 1'b0;
    expect_fetch("ack+redir", 32'h300);

    // PC wrap-around.
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    expect_hold("hold300", 32'h300);
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC; instr_ready = 1'b0;
    step();
    redirect = 1'b0; instr_ready = 1'b1;
    expect_fetch("top", 32'hFFFF_FFFC);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    expect_hold("holdtop", 32'hFFFF_FFFC);
    step();
    expect_fetch("wrap", 32'h0);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    step();
    expect_fetch("addr4", 32'h4);

    // Misaligned redirect during fetch -> FAULT on ack.
    redirect = 1'b1; redirect_target = 32'h102;
    step();
    redirect = 1'b0;
    check("pre fault", 32'(fetch_fault), 32'd0);
    man_ack = 1'b1;
    step();
    check("fault",       32'(fetch_fault), 32'd1);
    check("fault req",   32'(imem_req), 32'd0);
    check("fault addr",  imem_addr, 32'h4);
    check("fault instr", instr, 32'h13);
    redirect = 1'b1; redirect_target = 32'h400;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("sticky%0d", i), 32'(fetch_fault), 32'd1);
      check($sformatf("sticky req%0d", i), 32'(imem_req), 32'd0);
    end
    redirect = 1'b0; man_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("clr fault", 32'(fetch_fault), 32'd0);
    check("clr addr",  imem_addr, 32'h0);

    // Asynchronous reset mid-request.
    step();
    rst_n = 1'b1;
    step();
    expect_fetch("refetch", 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async req", 32'(imem_req), 32'd0);
    man_ack = 1'b1;
    step();
    check("ack ignored", 32'(instr_valid), 32'd0);
    man_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
